// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin arbiter between two byte sources, framing each grant as
// preamble, sync, fixed payload and idle gap, serialized MSB-first at CLKS_PER_BIT clocks per bit.
module tx_frame_scheduler #(
   parameter int          CLKS_PER_BIT  = 16,
   parameter int          PAYLOAD_BYTES = 2,
   parameter int          GAP_BITS      = 4,
   parameter logic [7:0]  PREAMBLE      = 8'hAA,
   parameter logic [7:0]  SYNC          = 8'h7E
) (
   input  logic       transmitter_clk,
   input  logic       transmitter_rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx_bit,
   output logic       tx_en,
   output logic       busy,
   output logic [1:0] grant,
   output logic       frame_done,
   output logic       underrun
);
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_PAY, S_GAP} state_t;
   localparam int CW = $clog2(CLKS_PER_BIT);

   state_t        state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [15:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]    byte_cnt_q, byte_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          rr_q, rr_d;
   logic [1:0]    grant_q, grant_d;
   logic          tx_bit_q, tx_bit_d, tx_en_q, tx_en_d, busy_q, busy_d;
   logic          tick, byte_end, last_byte, need, own_valid, pick;
   logic [7:0]    own_data, load;

   assign tick       = clk_cnt_q == CW'(CLKS_PER_BIT - 1);
   assign byte_end   = tick && bit_cnt_q == 16'd7;
   assign last_byte  = byte_cnt_q == 8'(PAYLOAD_BYTES - 1);
   assign need       = byte_end && (state_q == S_SYNC || (state_q == S_PAY && !last_byte));
   assign own_valid  = grant_q[0] ? req0_valid : grant_q[1] & req1_valid;
   assign own_data   = grant_q[0] ? req0_data : req1_data;
   // a missing byte is replaced by zeros so the frame timing never stretches
   assign load       = own_valid ? own_data : 8'h00;
   assign req0_ready = need & grant_q[0] & req0_valid;
   assign req1_ready = need & grant_q[1] & req1_valid;
   assign underrun   = need & ~own_valid;
   assign frame_done = state_q == S_GAP && tick && bit_cnt_q == 16'(GAP_BITS - 1);

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      pick       = (rr_q ? req1_valid : req0_valid) ? rr_q : ~rr_q;
      if (state_q == S_IDLE) begin
         if (req0_valid | req1_valid) begin
            state_d    = S_PRE;
            grant_d    = pick ? 2'b10 : 2'b01;
            rr_d       = ~pick;
            shift_d    = PREAMBLE;
            clk_cnt_d  = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
         end
      end else begin
         clk_cnt_d = tick ? '0 : clk_cnt_q + 1'b1;
         if (tick) begin
            bit_cnt_d = (byte_end && state_q != S_GAP) ? 16'd0 : bit_cnt_q + 16'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            case (state_q)
               S_PRE:  if (byte_end) begin
                  state_d = S_SYNC;
                  shift_d = SYNC;
               end
               S_SYNC: if (byte_end) begin
                  state_d    = S_PAY;
                  shift_d    = load;
                  byte_cnt_d = '0;
               end
               S_PAY:  if (byte_end) begin
                  state_d    = last_byte ? S_GAP : S_PAY;
                  shift_d    = last_byte ? 8'h00 : load;
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
               S_GAP:  if (frame_done) begin
                  state_d = S_IDLE;
                  grant_d = 2'b00;
               end
               default: ;
            endcase
         end
      end
   end

   // outputs are registered from next-state values so they line up with the shift register
   assign tx_en_d  = state_d == S_PRE || state_d == S_SYNC || state_d == S_PAY;
   assign tx_bit_d = tx_en_d & shift_d[7];
   assign busy_d   = state_d != S_IDLE;

   always_ff @(posedge transmitter_clk or posedge transmitter_rst) begin
      if (transmitter_rst) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         rr_q       <= 1'b0;
         grant_q    <= 2'b00;
         tx_bit_q   <= 1'b0;
         tx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         tx_bit_q   <= tx_bit_d;
         tx_en_q    <= tx_en_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_bit = tx_bit_q;
   assign tx_en  = tx_en_q;
   assign busy   = busy_q;
   assign grant  = grant_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: randomized scenarios on a default instance and a minimal-parameter
// instance, checked against a frame-level model of preamble/sync/payload/gap and round-robin.
module tb_tx_frame_scheduler;
   logic       clk = 1'b0, rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_ready, req1_ready, tx_bit, tx_en, busy, frame_done, underrun;
   logic [1:0] grant;
   logic       b_v0 = 1'b0, b_v1 = 1'b0;
   logic [7:0] b_d0 = 8'h00, b_d1 = 8'h00;
   logic       b_r0, b_r1, b_tx_bit, b_tx_en, b_busy, b_done, b_und;
   logic [1:0] b_grant;

   always #5 clk = ~clk;

   tx_frame_scheduler dut (
      .transmitter_clk(clk), .transmitter_rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx_bit(tx_bit), .tx_en(tx_en), .busy(busy), .grant(grant),
      .frame_done(frame_done), .underrun(underrun));

   tx_frame_scheduler #(.CLKS_PER_BIT(2), .PAYLOAD_BYTES(1), .GAP_BITS(1)) dut_b (
      .transmitter_clk(clk), .transmitter_rst(rst),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
      .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
      .tx_bit(b_tx_bit), .tx_en(b_tx_en), .busy(b_busy), .grant(b_grant),
      .frame_done(b_done), .underrun(b_und));

   int checks = 0, passed = 0;
   logic [7:0] seq [2][64];
   int idx [2], lim [2];
   logic en [2];
   logic hs0, hs1;
   int rr_m;

   logic [35:0] cap_bits;
   int cap_len, cap_en, cap_done_at, cap_done_n, cap_r0, cap_r1, cap_und, cap_idle;
   logic [1:0] cap_gnt;
   logic cap_stable;

   function automatic logic src_valid(input int s);
      return en[s] && idx[s] < lim[s];
   endfunction

   function automatic int next_owner();
      return src_valid(rr_m) ? rr_m : 1 - rr_m;
   endfunction

   function automatic logic [7:0] exp_byte(input int o, input int i);
      return (en[o] && i < lim[o]) ? seq[o][i] : 8'h00;
   endfunction

   function automatic logic [35:0] exp_frame(input int o, input int start);
      return {8'hAA, 8'h7E, exp_byte(o, start), exp_byte(o, start + 1), 4'b0000};
   endfunction

   task automatic drive_src();
      req0_valid = src_valid(0);
      req0_data  = seq[0][idx[0] % 64];
      req1_valid = src_valid(1);
      req1_data  = seq[1][idx[1] % 64];
   endtask

   // called at a negedge: record handshakes, cross the posedge, then present next bytes
   task automatic advance();
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (hs0) idx[0]++;
      if (hs1) idx[1]++;
      drive_src();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rr_m = 0;
   endtask

   task automatic fill(input int s);
      for (int i = 0; i < 64; i++) seq[s][i] = 8'($urandom);
      idx[s] = 0;
   endtask

   // starts at a negedge, waits for the next frame and records it up to its first idle cycle
   task automatic capture();
      int c;
      logic first;
      cap_bits = '0; cap_en = 0; cap_done_at = -1; cap_done_n = 0;
      cap_r0 = 0; cap_r1 = 0; cap_und = 0; cap_idle = 0; cap_stable = 1'b1; first = 1'b0;
      while (!busy && cap_idle < 300) begin
         advance();
         @(negedge clk);
         cap_idle++;
      end
      cap_gnt = grant;
      c = 0;
      while (busy && c < 1000) begin
         if (c % 16 == 0) first = tx_bit;
         else if (tx_bit !== first) cap_stable = 1'b0;
         if (c % 16 == 8) cap_bits = {cap_bits[34:0], tx_bit};
         if (grant !== cap_gnt) cap_stable = 1'b0;
         if (tx_en) cap_en++;
         if (frame_done) begin cap_done_n++; cap_done_at = c + 1; end
         if (req0_ready) cap_r0++;
         if (req1_ready) cap_r1++;
         if (underrun) cap_und++;
         advance();
         @(negedge clk);
         c++;
      end
      cap_len = c;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({tx_bit, tx_en, busy, grant, req0_ready, req1_ready, frame_done, underrun} !== 9'd0)
         $display("FAIL reset_a outputs=%b want 0", {tx_bit, tx_en, busy, grant, req0_ready, req1_ready, frame_done, underrun});
      else passed++;
      checks++;
      if ({b_tx_bit, b_tx_en, b_busy, b_grant, b_r0, b_r1, b_done, b_und} !== 9'd0)
         $display("FAIL reset_b outputs=%b want 0", {b_tx_bit, b_tx_en, b_busy, b_grant, b_r0, b_r1, b_done, b_und});
      else passed++;
      rst = 1'b0;
      rr_m = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, grant} !== 3'b000) $display("FAIL idle_no_valid busy,grant=%b want 000", {busy, grant});
      else passed++;
   endtask

   task automatic test_single();
      do_reset();
      seq[0][0] = 8'h35; seq[0][1] = 8'hC4; idx[0] = 0; lim[0] = 2; en[0] = 1'b1; en[1] = 1'b0;
      drive_src();
      capture();
      checks++;
      if (cap_bits !== 36'hAA7E35C40) $display("FAIL single_bits got=%h want=%h", cap_bits, 36'hAA7E35C40);
      else passed++;
      checks++;
      if (cap_gnt !== 2'b01) $display("FAIL single_grant got=%b want=01", cap_gnt);
      else passed++;
      checks++;
      if (cap_len !== 576 || cap_en !== 512) $display("FAIL single_len len=%0d en=%0d want 576/512", cap_len, cap_en);
      else passed++;
      checks++;
      if (cap_done_n !== 1 || cap_done_at !== 576) $display("FAIL single_done n=%0d at=%0d want 1/576", cap_done_n, cap_done_at);
      else passed++;
      checks++;
      if (cap_r0 !== 2 || cap_und !== 0 || !cap_stable) $display("FAIL single_hs r0=%0d und=%0d stable=%b want 2/0/1", cap_r0, cap_und, cap_stable);
      else passed++;
      checks++;
      if (cap_idle !== 1) $display("FAIL single_latency idle=%0d want 1", cap_idle);
      else passed++;
   endtask

   task automatic test_round_robin();
      int o, start;
      do_reset();
      fill(0); fill(1);
      lim[0] = 64; lim[1] = 64; en[0] = 1'b1; en[1] = 1'b1;
      drive_src();
      for (int f = 0; f < 4; f++) begin
         o = next_owner();
         start = idx[o];
         rr_m = 1 - o;
         capture();
         checks++;
         if (cap_gnt !== (o == 1 ? 2'b10 : 2'b01)) $display("FAIL rr_grant frame %0d got=%b want owner %0d", f, cap_gnt, o);
         else passed++;
         checks++;
         if (cap_bits !== exp_frame(o, start)) $display("FAIL rr_bits frame %0d got=%h want=%h", f, cap_bits, exp_frame(o, start));
         else passed++;
         checks++;
         if ((o == 0 ? {cap_r0, cap_r1} : {cap_r1, cap_r0}) !== {32'd2, 32'd0})
            $display("FAIL rr_ready frame %0d r0=%0d r1=%0d want 2 for owner %0d only", f, cap_r0, cap_r1, o);
         else passed++;
         checks++;
         if (cap_len !== 576 || cap_idle !== 1 || cap_und !== 0)
            $display("FAIL rr_timing frame %0d len=%0d idle=%0d und=%0d want 576/1/0", f, cap_len, cap_idle, cap_und);
         else passed++;
      end
   endtask

   task automatic test_underrun();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         fill(0);
         lim[0] = 1; en[0] = 1'b1; en[1] = 1'b0;
         drive_src();
         capture();
         checks++;
         if (cap_bits !== exp_frame(0, 0)) $display("FAIL underrun_bits got=%h want=%h", cap_bits, exp_frame(0, 0));
         else passed++;
         checks++;
         if (cap_und !== 1 || cap_r0 !== 1) $display("FAIL underrun_pulse und=%0d r0=%0d want 1/1", cap_und, cap_r0);
         else passed++;
         checks++;
         if (cap_len !== 576 || cap_done_at !== 576) $display("FAIL underrun_len len=%0d done=%0d want 576/576", cap_len, cap_done_at);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int o, start, w;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         fill(0); fill(1);
         lim[0] = 64; lim[1] = 64; en[0] = 1'b1; en[1] = 1'b0;
         drive_src();
         w = 0;
         while (!busy && w < 300) begin advance(); @(negedge clk); w++; end
         repeat (400) begin advance(); @(negedge clk); end
         checks++;
         if ({busy, tx_en} !== 2'b11) $display("FAIL midframe_active busy,tx_en=%b want 11", {busy, tx_en});
         else passed++;
         #2 rst = 1'b1;
         #1;
         checks++;
         if ({tx_bit, tx_en, busy, grant, req0_ready, req1_ready, frame_done, underrun} !== 9'd0)
            $display("FAIL async_reset outputs=%b want 0", {tx_bit, tx_en, busy, grant, req0_ready, req1_ready, frame_done, underrun});
         else passed++;
         @(negedge clk);
         rst = 1'b0;
         rr_m = 0;
         en[0] = 1'($urandom_range(0, 1)); en[1] = 1'b1;
         drive_src();
         o = next_owner();
         start = idx[o];
         rr_m = 1 - o;
         capture();
         checks++;
         if (cap_gnt !== (o == 1 ? 2'b10 : 2'b01)) $display("FAIL post_reset_grant got=%b want owner %0d", cap_gnt, o);
         else passed++;
         checks++;
         if (cap_bits !== exp_frame(o, start) || cap_len !== 576)
            $display("FAIL post_reset_frame bits=%h len=%0d want %h/576", cap_bits, cap_len, exp_frame(o, start));
         else passed++;
      end
   endtask

   task automatic test_hold_off();
      int w, c, r1, start;
      do_reset();
      fill(0); fill(1);
      lim[0] = 64; lim[1] = 64; en[0] = 1'b1; en[1] = 1'b0;
      drive_src();
      w = 0;
      while (!busy && w < 300) begin advance(); @(negedge clk); w++; end
      checks++;
      if (grant !== 2'b01) $display("FAIL holdoff_owner got=%b want 01", grant);
      else passed++;
      rr_m = 1;
      c = 0; r1 = 0;
      while (busy && c < 1000) begin
         if (c == 100) en[1] = 1'b1;
         if (req1_ready) r1++;
         advance();
         @(negedge clk);
         c++;
      end
      checks++;
      if (r1 !== 0 || c !== 576) $display("FAIL holdoff_ready r1=%0d len=%0d want 0/576", r1, c);
      else passed++;
      start = idx[next_owner()];
      checks++;
      if (next_owner() !== 1) $display("FAIL holdoff_model owner=%0d want 1", next_owner());
      else passed++;
      rr_m = 0;
      capture();
      checks++;
      if (cap_gnt !== 2'b10 || cap_idle !== 1) $display("FAIL holdoff_next grant=%b idle=%0d want 10/1", cap_gnt, cap_idle);
      else passed++;
      checks++;
      if (cap_bits !== exp_frame(1, start) || cap_r0 !== 0) $display("FAIL holdoff_bits got=%h r0=%0d want %h/0", cap_bits, cap_r0, exp_frame(1, start));
      else passed++;
      en[0] = 1'b0; en[1] = 1'b0;
      drive_src();
   endtask

   task automatic test_corner();
      int w, c, brr, o, rdy, done_at;
      logic [24:0] bits, want;
      do_reset();
      en[0] = 1'b0; en[1] = 1'b0;
      drive_src();
      b_d0 = 8'($urandom); b_d1 = 8'($urandom); b_v0 = 1'b1; b_v1 = 1'b1;
      brr = 0;
      for (int f = 0; f < 3; f++) begin
         o = brr;
         brr = 1 - o;
         w = 0;
         while (!b_busy && w < 100) begin @(negedge clk); w++; end
         checks++;
         if (b_grant !== (o == 1 ? 2'b10 : 2'b01) || w !== 1) $display("FAIL corner_grant frame %0d grant=%b idle=%0d want owner %0d idle 1", f, b_grant, w, o);
         else passed++;
         c = 0; rdy = 0; done_at = -1; bits = '0;
         while (b_busy && c < 200) begin
            if (c % 2 == 1) bits = {bits[23:0], b_tx_bit};
            if (b_r0 | b_r1) rdy++;
            if (b_done) done_at = c + 1;
            @(negedge clk);
            c++;
         end
         want = {8'hAA, 8'h7E, (o == 1 ? b_d1 : b_d0), 1'b0};
         checks++;
         if (bits !== want) $display("FAIL corner_bits frame %0d got=%h want=%h", f, bits, want);
         else passed++;
         checks++;
         if (c !== 50 || done_at !== 50 || rdy !== 1) $display("FAIL corner_len frame %0d len=%0d done=%0d rdy=%0d want 50/50/1", f, c, done_at, rdy);
         else passed++;
      end
      b_v0 = 1'b0; b_v1 = 1'b0;
   endtask

   initial begin
      en[0] = 1'b0; en[1] = 1'b0; idx[0] = 0; idx[1] = 0; lim[0] = 0; lim[1] = 0; rr_m = 0;
      fill(0); fill(1);
      test_reset();
      test_single();
      test_round_robin();
      test_underrun();
      test_reset_mid();
      test_hold_off();
      test_corner();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
